// File: rtl/alu_rs_pkg.sv
// Shared constants for the ALU reservation station: sizes, flag values and ALU op codes.
package alu_rs_pkg;

  localparam int unsigned RS_SIZE_DEF = 4;
  localparam int unsigned TAG_W_DEF   = 4;
  localparam int unsigned OP_W        = 4;
  localparam int unsigned DATA_W      = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_e;

  // Index width for an n-entry table; never zero so single-entry builds stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority encoder: reports whether any request is set and which one wins.
module rs_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last (winning) write.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued ops until operands arrive over the CDB,
// dispatches the lowest ready entry to the ALU and broadcasts its result one cycle later.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned RS_SIZE = RS_SIZE_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              issue_qj_busy,
  input  logic              issue_qk_busy,
  input  logic [TAG_W-1:0]  issue_dest,
  output logic              rs_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              alu_ready,
  output logic [DATA_W-1:0] alu_lv,
  output logic [DATA_W-1:0] alu_rv,
  output logic [OP_W-1:0]   alu_op,
  input  logic              alu_success,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_value
);

  localparam int unsigned IW = idx_w(RS_SIZE);

  // Per-entry control flags (reset) and payload (no reset needed; gated by busy).
  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_busy;
  logic [RS_SIZE-1:0] qk_busy;
  logic [OP_W-1:0]    ent_op   [RS_SIZE];
  logic [DATA_W-1:0]  ent_vj   [RS_SIZE];
  logic [DATA_W-1:0]  ent_vk   [RS_SIZE];
  logic [TAG_W-1:0]   ent_qj   [RS_SIZE];
  logic [TAG_W-1:0]   ent_qk   [RS_SIZE];
  logic [TAG_W-1:0]   ent_dest [RS_SIZE];

  logic               free_any;
  logic               ready_any;
  logic [IW-1:0]      free_idx;
  logic [IW-1:0]      ready_idx;
  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [RS_SIZE-1:0] issue_sel;
  logic [RS_SIZE-1:0] fire_sel;
  logic [RS_SIZE-1:0] cap_j;
  logic [RS_SIZE-1:0] cap_k;
  logic               live;
  logic               do_issue;
  logic               do_fire;
  logic               fwd_j;
  logic               fwd_k;

  assign free_vec  = ~busy;
  assign ready_vec = busy & ~qj_busy & ~qk_busy;

  rs_pick #(.N(RS_SIZE), .IW(IW)) u_free_pick (
    .req   (free_vec),
    .valid (free_any),
    .idx   (free_idx)
  );

  rs_pick #(.N(RS_SIZE), .IW(IW)) u_ready_pick (
    .req   (ready_vec),
    .valid (ready_any),
    .idx   (ready_idx)
  );

  // Station state only moves when running and not being flushed.
  assign live      = rdy & ~flush;
  assign rs_full   = ~free_any;
  assign alu_ready = rdy & ready_any;
  assign alu_op    = alu_ready ? ent_op[ready_idx] : '0;
  assign alu_lv    = alu_ready ? ent_vj[ready_idx] : '0;
  assign alu_rv    = alu_ready ? ent_vk[ready_idx] : '0;

  assign do_issue = live & issue_valid & free_any;
  assign do_fire  = live & alu_ready & alu_success;
  assign fwd_j    = live & cdb_valid & issue_qj_busy & (cdb_tag == issue_qj);
  assign fwd_k    = live & cdb_valid & issue_qk_busy & (cdb_tag == issue_qk);

  // Per-entry strobes; an entry leaving this cycle never snoops the CDB.
  always_comb begin
    issue_sel = '0;
    fire_sel  = '0;
    cap_j     = '0;
    cap_k     = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      issue_sel[i] = do_issue & (free_idx == IW'(i));
      fire_sel[i]  = do_fire & (ready_idx == IW'(i));
      cap_j[i]     = live & cdb_valid & busy[i] & qj_busy[i] &
                     (ent_qj[i] == cdb_tag) & ~fire_sel[i];
      cap_k[i]     = live & cdb_valid & busy[i] & qk_busy[i] &
                     (ent_qk[i] == cdb_tag) & ~fire_sel[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= '0;
      qj_busy   <= '0;
      qk_busy   <= '0;
      out_valid <= FALSE;
      out_tag   <= '0;
      out_value <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy      <= '0;
        qj_busy   <= '0;
        qk_busy   <= '0;
        out_valid <= FALSE;
      end else begin
        out_valid <= do_fire;
        if (do_fire) begin
          out_tag   <= ent_dest[ready_idx];
          out_value <= alu_result;
        end
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (issue_sel[i]) begin
            busy[i]    <= TRUE;
            qj_busy[i] <= issue_qj_busy & ~fwd_j;
            qk_busy[i] <= issue_qk_busy & ~fwd_k;
          end else begin
            if (fire_sel[i]) busy[i]    <= FALSE;
            if (cap_j[i])    qj_busy[i] <= FALSE;
            if (cap_k[i])    qk_busy[i] <= FALSE;
          end
        end
      end
    end
  end

  // Payload write: issue (with same-cycle CDB forwarding) or operand capture.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (issue_sel[i]) begin
        ent_op[i]   <= issue_op;
        ent_vj[i]   <= fwd_j ? cdb_value : issue_vj;
        ent_vk[i]   <= fwd_k ? cdb_value : issue_vk;
        ent_qj[i]   <= issue_qj;
        ent_qk[i]   <= issue_qk;
        ent_dest[i] <= issue_dest;
      end else begin
        if (cap_j[i]) ent_vj[i] <= cdb_value;
        if (cap_k[i]) ent_vk[i] <= cdb_value;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus randomized traffic against an entry-table model.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy, flush, issue_valid;
  logic [3:0]  issue_op;
  logic [31:0] issue_vj, issue_vk;
  logic [3:0]  issue_qj, issue_qk;
  logic        issue_qj_busy, issue_qk_busy;
  logic [3:0]  issue_dest;
  logic        rs_full;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        alu_ready;
  logic [31:0] alu_lv, alu_rv;
  logic [3:0]  alu_op;
  logic        alu_success;
  logic [31:0] alu_result;
  logic        out_valid;
  logic [3:0]  out_tag;
  logic [31:0] out_value;

  int total = 0;
  int bad   = 0;

  alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_dest(issue_dest), .rs_full(rs_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_ready(alu_ready), .alu_lv(alu_lv), .alu_rv(alu_rv), .alu_op(alu_op),
    .alu_success(alu_success), .alu_result(alu_result),
    .out_valid(out_valid), .out_tag(out_tag), .out_value(out_value)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    case (o)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return 32'($signed(a) >>> b[4:0]);
      OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'b0, a < b};
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural ALU sitting behind the station.
  always_comb alu_result = alu_ref(alu_op, alu_lv, alu_rv);

  task automatic idle();
    issue_valid = 1'b0; issue_op = 4'd0; issue_vj = 32'd0; issue_vk = 32'd0;
    issue_qj = 4'd0; issue_qk = 4'd0; issue_qj_busy = 1'b0; issue_qk_busy = 1'b0;
    issue_dest = 4'd0; cdb_valid = 1'b0; cdb_tag = 4'd0; cdb_value = 32'd0;
    flush = 1'b0; rdy = 1'b1;
  endtask

  task automatic put(input logic [3:0] o, input logic [31:0] vj, input logic [31:0] vk,
                     input logic jb, input logic [3:0] qj, input logic kb,
                     input logic [3:0] qk, input logic [3:0] dest);
    issue_valid = 1'b1; issue_op = o; issue_vj = vj; issue_vk = vk;
    issue_qj_busy = jb; issue_qj = qj; issue_qk_busy = kb; issue_qk = qk; issue_dest = dest;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); alu_success = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({rs_full, alu_ready} !== 2'b00) begin bad++;
      $display("FAIL reset_flags: got full=%b ready=%b want 0 0", rs_full, alu_ready); end
    total++; if ({alu_lv, alu_rv, alu_op} !== 68'd0) begin bad++;
      $display("FAIL reset_alu_bus: got lv=%h rv=%h op=%h want 0", alu_lv, alu_rv, alu_op); end
    total++; if ({out_valid, out_tag, out_value} !== 37'd0) begin bad++;
      $display("FAIL reset_out: got v=%b tag=%h val=%h want 0", out_valid, out_tag, out_value); end
    rst = 1'b1;
    tick();
    total++; if ({rs_full, alu_ready, out_valid} !== 3'b000) begin bad++;
      $display("FAIL post_reset: got full=%b ready=%b ov=%b want 0", rs_full, alu_ready, out_valid); end
  endtask

  task automatic test_add();
    alu_success = 1'b1;
    put(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    tick(); idle(); #1;
    total++; if ({alu_ready, alu_lv, alu_rv, alu_op} !== {1'b1, 32'd5, 32'd7, 4'(OP_ADD)}) begin bad++;
      $display("FAIL add_dispatch: got rdy=%b lv=%0d rv=%0d op=%0d want 1 5 7 0", alu_ready, alu_lv, alu_rv, alu_op); end
    tick();
    total++; if ({out_valid, out_tag, out_value} !== {1'b1, 4'd3, 32'd12}) begin bad++;
      $display("FAIL add_result: got v=%b tag=%0d val=%0d want 1 3 12", out_valid, out_tag, out_value); end
    total++; if (alu_ready !== 1'b0) begin bad++;
      $display("FAIL add_freed: got alu_ready=%b want 0", alu_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL add_single_pulse: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_cdb_wake();
    put(OP_ADD, 32'hdead, 32'd4, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
    tick(); idle(); #1;
    total++; if (alu_ready !== 1'b0) begin bad++;
      $display("FAIL wake_pending: got alu_ready=%b want 0", alu_ready); end
    tick(); cdb(4'd2, 32'd10); #1;
    total++; if (alu_ready !== 1'b0) begin bad++;
      $display("FAIL wake_cdb_cycle: got alu_ready=%b want 0", alu_ready); end
    tick(); idle(); #1;
    total++; if ({alu_ready, alu_lv, alu_rv} !== {1'b1, 32'd10, 32'd4}) begin bad++;
      $display("FAIL wake_dispatch: got rdy=%b lv=%0d rv=%0d want 1 10 4", alu_ready, alu_lv, alu_rv); end
    tick();
    total++; if ({out_valid, out_tag, out_value} !== {1'b1, 4'd5, 32'd14}) begin bad++;
      $display("FAIL wake_result: got v=%b tag=%0d val=%0d want 1 5 14", out_valid, out_tag, out_value); end
  endtask

  task automatic test_issue_fwd();
    put(OP_ADD, 32'd1, 32'hbeef, 1'b0, 4'd0, 1'b1, 4'd6, 4'd7);
    cdb(4'd6, 32'd9);
    tick(); idle(); #1;
    total++; if ({alu_ready, alu_rv} !== {1'b1, 32'd9}) begin bad++;
      $display("FAIL fwd_capture: got rdy=%b rv=%0d want 1 9", alu_ready, alu_rv); end
    tick();
    total++; if ({out_valid, out_tag, out_value} !== {1'b1, 4'd7, 32'd10}) begin bad++;
      $display("FAIL fwd_result: got v=%b tag=%0d val=%0d want 1 7 10", out_valid, out_tag, out_value); end
    tick();
  endtask

  task automatic test_full();
    alu_success = 1'b1;
    for (int k = 0; k < 4; k++) begin
      put(OP_ADD, 32'(k), 32'd1, 1'b1, 4'(8 + k), 1'b0, 4'd0, 4'(k));
      tick();
    end
    idle(); #1;
    total++; if ({rs_full, alu_ready} !== 2'b10) begin bad++;
      $display("FAIL full_set: got full=%b ready=%b want 1 0", rs_full, alu_ready); end
    put(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
    tick(); idle(); #1;
    total++; if ({rs_full, alu_ready} !== 2'b10) begin bad++;
      $display("FAIL full_drop: got full=%b ready=%b want 1 0", rs_full, alu_ready); end
    cdb(4'd8, 32'd3);
    tick(); idle(); #1;
    total++; if ({alu_ready, alu_lv, rs_full} !== {1'b1, 32'd3, 1'b1}) begin bad++;
      $display("FAIL full_wake: got rdy=%b lv=%0d full=%b want 1 3 1", alu_ready, alu_lv, rs_full); end
    tick();
    total++; if ({out_valid, out_tag, out_value, rs_full} !== {1'b1, 4'd0, 32'd4, 1'b0}) begin bad++;
      $display("FAIL full_release: got v=%b tag=%0d val=%0d full=%b want 1 0 4 0", out_valid, out_tag, out_value, rs_full); end
    flush = 1'b1;
    tick(); idle();
  endtask

  task automatic test_order_flush();
    alu_success = 1'b0;
    put(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1); tick();
    put(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd13, 1'b0, 4'd0, 4'd9); tick();
    put(OP_ADD, 32'd2, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2); tick();
    idle(); #1;
    total++; if ({alu_ready, alu_lv, rs_full} !== {1'b1, 32'd1, 1'b0}) begin bad++;
      $display("FAIL order_hold: got rdy=%b lv=%0d full=%b want 1 1 0", alu_ready, alu_lv, rs_full); end
    alu_success = 1'b1;
    tick();
    total++; if ({out_valid, out_tag, out_value} !== {1'b1, 4'd1, 32'd2}) begin bad++;
      $display("FAIL order_first: got v=%b tag=%0d val=%0d want 1 1 2", out_valid, out_tag, out_value); end
    tick();
    total++; if ({out_valid, out_tag, out_value} !== {1'b1, 4'd2, 32'd4}) begin bad++;
      $display("FAIL order_second: got v=%b tag=%0d val=%0d want 1 2 4", out_valid, out_tag, out_value); end
    alu_success = 1'b0;
    tick();
    put(OP_ADD, 32'd5, 32'd5, 1'b0, 4'd0, 1'b0, 4'd0, 4'd11); tick();
    put(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd14, 1'b0, 4'd0, 4'd12); tick();
    idle(); #1;
    total++; if ({alu_ready, alu_lv} !== {1'b1, 32'd5}) begin bad++;
      $display("FAIL flush_setup: got rdy=%b lv=%0d want 1 5", alu_ready, alu_lv); end
    flush = 1'b1; alu_success = 1'b1;
    tick(); idle(); #1;
    total++; if ({out_valid, rs_full, alu_ready} !== 3'b000) begin bad++;
      $display("FAIL flush_clear: got ov=%b full=%b ready=%b want 0 0 0", out_valid, rs_full, alu_ready); end
    cdb(4'd13, 32'd1);
    tick(); idle(); #1;
    total++; if (alu_ready !== 1'b0) begin bad++;
      $display("FAIL flush_stale_wake: got alu_ready=%b want 0", alu_ready); end
    tick();
  endtask

  task automatic test_rdy_hold();
    alu_success = 1'b1;
    put(OP_SUB, 32'd20, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
    tick();
    for (int c = 0; c < 3; c++) begin
      idle(); rdy = 1'b0; flush = 1'b1; cdb(4'd1, 32'd77);
      put(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
      #1;
      total++; if ({alu_ready, out_valid} !== 2'b00) begin bad++;
        $display("FAIL hold_%0d: got ready=%b ov=%b want 0 0", c, alu_ready, out_valid); end
      tick();
    end
    idle(); #1;
    total++; if ({alu_ready, alu_lv, alu_rv, alu_op} !== {1'b1, 32'd20, 32'd3, 4'(OP_SUB)}) begin bad++;
      $display("FAIL hold_resume: got rdy=%b lv=%0d rv=%0d op=%0d want 1 20 3 1", alu_ready, alu_lv, alu_rv, alu_op); end
    tick();
    total++; if ({out_valid, out_tag, out_value, alu_ready} !== {1'b1, 4'd4, 32'd17, 1'b0}) begin bad++;
      $display("FAIL hold_result: got v=%b tag=%0d val=%0d rdy=%b want 1 4 17 0", out_valid, out_tag, out_value, alu_ready); end
    rdy = 1'b0;
    tick();
    total++; if ({out_valid, out_value} !== {1'b1, 32'd17}) begin bad++;
      $display("FAIL hold_out: got v=%b val=%0d want 1 17", out_valid, out_value); end
    rdy = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    alu_success = 1'b1;
    put(OP_ADD, 32'd8, 32'd8, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6); tick();
    put(OP_ADD, 32'd1, 32'd1, 1'b1, 4'd5, 1'b0, 4'd0, 4'd13); tick();
    idle();
    total++; if ({out_valid, out_tag, out_value} !== {1'b1, 4'd6, 32'd16}) begin bad++;
      $display("FAIL mid_pre: got v=%b tag=%0d val=%0d want 1 6 16", out_valid, out_tag, out_value); end
    rst = 1'b0; #1;
    total++; if ({out_valid, out_tag, out_value, rs_full, alu_ready} !== 39'd0) begin bad++;
      $display("FAIL mid_reset: got v=%b tag=%0d val=%0d full=%b rdy=%b want 0", out_valid, out_tag, out_value, rs_full, alu_ready); end
    #2; rst = 1'b1;
    tick(); cdb(4'd5, 32'd1);
    tick(); idle(); #1;
    total++; if (alu_ready !== 1'b0) begin bad++;
      $display("FAIL mid_discard: got alu_ready=%b want 0", alu_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL mid_no_bcast: got out_valid=%b want 0", out_valid); end
  endtask

  // Entry-table model of the station's documented behaviour.
  bit        m_busy [N];
  bit        m_pj   [N];
  bit        m_pk   [N];
  bit [3:0]  m_op   [N];
  bit [31:0] m_vj   [N];
  bit [31:0] m_vk   [N];
  bit [3:0]  m_qj   [N];
  bit [3:0]  m_qk   [N];
  bit [3:0]  m_dest [N];
  bit        m_ov;
  bit [3:0]  m_ot;
  bit [31:0] m_oval;

  function automatic int m_ready_slot();
    for (int i = 0; i < N; i++)
      if (m_busy[i] && !m_pj[i] && !m_pk[i]) return i;
    return -1;
  endfunction

  function automatic int m_free_slot();
    for (int i = 0; i < N; i++)
      if (!m_busy[i]) return i;
    return -1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_pj[i] = 0; m_pk[i] = 0; end
  endtask

  task automatic m_step();
    int sel, slot;
    if (!rdy) return;
    if (flush) begin m_clear(); m_ov = 0; return; end
    sel  = m_ready_slot();
    slot = m_free_slot();
    m_ov = (sel >= 0) && alu_success;
    if (m_ov) begin
      m_ot   = m_dest[sel];
      m_oval = alu_ref(m_op[sel], m_vj[sel], m_vk[sel]);
      m_busy[sel] = 0;
    end
    if (cdb_valid)
      for (int i = 0; i < N; i++)
        if (m_busy[i]) begin
          if (m_pj[i] && m_qj[i] == cdb_tag) begin m_vj[i] = cdb_value; m_pj[i] = 0; end
          if (m_pk[i] && m_qk[i] == cdb_tag) begin m_vk[i] = cdb_value; m_pk[i] = 0; end
        end
    if (issue_valid && slot >= 0) begin
      m_busy[slot] = 1; m_op[slot] = issue_op; m_dest[slot] = issue_dest;
      m_qj[slot] = issue_qj; m_qk[slot] = issue_qk;
      m_pj[slot] = issue_qj_busy; m_vj[slot] = issue_vj;
      m_pk[slot] = issue_qk_busy; m_vk[slot] = issue_vk;
      if (issue_qj_busy && cdb_valid && cdb_tag == issue_qj) begin m_pj[slot] = 0; m_vj[slot] = cdb_value; end
      if (issue_qk_busy && cdb_valid && cdb_tag == issue_qk) begin m_pk[slot] = 0; m_vk[slot] = cdb_value; end
    end
  endtask

  task automatic test_random();
    int sel;
    bit full;
    logic [31:0] e_lv, e_rv;
    logic [3:0]  e_op;
    idle(); rst = 1'b0; #2; rst = 1'b1;
    m_clear(); m_ov = 0; m_ot = 0; m_oval = 0;
    tick();
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 39) == 0);
      alu_success = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        put(4'($urandom_range(0, 9)), $urandom, $urandom,
            ($urandom_range(0, 4) < 2), 4'($urandom_range(0, 3)),
            ($urandom_range(0, 4) < 2), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) < 2) cdb(4'($urandom_range(0, 3)), $urandom);
      #1;
      sel  = m_ready_slot();
      full = (m_free_slot() < 0);
      e_lv = 32'd0; e_rv = 32'd0; e_op = 4'd0;
      if (rdy && sel >= 0) begin e_lv = m_vj[sel]; e_rv = m_vk[sel]; e_op = m_op[sel]; end
      total++; if ({rs_full, alu_ready} !== {full, rdy && sel >= 0}) begin bad++;
        $display("FAIL rnd_flags cyc %0d: got full=%b ready=%b want %b %b", cyc, rs_full, alu_ready, full, rdy && sel >= 0); end
      total++; if ({alu_lv, alu_rv, alu_op} !== {e_lv, e_rv, e_op}) begin bad++;
        $display("FAIL rnd_alu_bus cyc %0d: got %h %h %h want %h %h %h", cyc, alu_lv, alu_rv, alu_op, e_lv, e_rv, e_op); end
      total++; if ({out_valid, out_tag, out_value} !== {m_ov, m_ot, m_oval}) begin bad++;
        $display("FAIL rnd_out cyc %0d: got %b %h %h want %b %h %h", cyc, out_valid, out_tag, out_value, m_ov, m_ot, m_oval); end
      m_step();
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_add();
    test_cdb_wake();
    test_issue_fwd();
    test_full();
    test_order_flush();
    test_rdy_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
